add_arbiter: RTL and testbench

ADD_ARBITER -- requirements
Module: add_arbiter

---
 rtl/add_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_add_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/add_arbiter.sv
// -----------------------------------------------------------------------------
// add_arbiter
//   Shares one external 8-bit ADD unit between two requesters. When the FSM is
//   IDLE and a request is seen, the winner's operands are registered onto
//   ADD_DATA1/ADD_DATA2 and a one-cycle grant pulse is issued. The FSM then
//   waits LAT edges and captures ADD_RESULT into RESULT. The captured sum is
//   announced with a one-cycle VALIDx pulse to the requester that was granted.
//
// Parameters
//   LAT          edges between the grant edge and the result capture (1..15)
//
// Configuration macro
//   ADD_ARB_ROUND_ROBIN_EN  defined   : simultaneous requests alternate, using
//                                       a last-grant register (reset to 1)
//                           undefined : simultaneous requests go to requester 0
//
// Ports
//   CLK                in   system clock, rising edge
//   RESET              in   synchronous active-high reset
//   REQ0, REQ1         in   add requests
//   DATA1_0, DATA2_0   in   requester 0 operands
//   DATA1_1, DATA2_1   in   requester 1 operands
//   GNT0, GNT1         out  one-cycle grant pulses
//   VALID0, VALID1     out  one-cycle result-ready pulses
//   RESULT             out  last captured sum, shared by both requesters
//   ADD_DATA1/2        out  registered operands to the ADD unit
//   ADD_RESULT         in   sum returned by the ADD unit
//   BUSY               out  high while an operation is in flight (WAIT)
// -----------------------------------------------------------------------------
module add_arbiter #(
   parameter int unsigned LAT = 1
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       REQ0,
   input  logic [7:0] DATA1_0,
   input  logic [7:0] DATA2_0,
   input  logic       REQ1,
   input  logic [7:0] DATA1_1,
   input  logic [7:0] DATA2_1,
   output logic       GNT0,
   output logic       GNT1,
   output logic       VALID0,
   output logic       VALID1,
   output logic [7:0] RESULT,
   output logic [7:0] ADD_DATA1,
   output logic [7:0] ADD_DATA2,
   input  logic [7:0] ADD_RESULT,
   output logic       BUSY
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   // The counter loads LAT-1 at the grant edge; the capture happens on the
   // edge that finds it at zero, i.e. exactly LAT edges after the grant.
   localparam logic [3:0] CNT_LOAD = 4'(LAT - 1);

   state_t     state_q;
   logic [3:0] cnt_q;
   logic       owner_q;      // requester of the operation currently in flight
   logic       gnt0_q;
   logic       gnt1_q;
   logic       valid0_q;
   logic       valid1_q;
   logic       busy_q;
   logic [7:0] result_q;
   logic [7:0] add_data1_q;
   logic [7:0] add_data2_q;

   logic       req_any_s;
   logic       pick1_s;      // 1 when requester 1 wins this edge

`ifdef ADD_ARB_ROUND_ROBIN_EN
   logic       last_q;       // requester granted most recently

   // Round-robin choice: on a tie, favour the requester not granted last.
   always_comb begin
      pick1_s = 1'b0;
      if (REQ0 && REQ1) begin
         pick1_s = ~last_q;
      end else if (REQ1) begin
         pick1_s = 1'b1;
      end else begin
         pick1_s = 1'b0;
      end
   end
`else
   // Fixed priority: requester 0 always wins a tie.
   always_comb begin
      pick1_s = 1'b0;
      if (REQ0) begin
         pick1_s = 1'b0;
      end else if (REQ1) begin
         pick1_s = 1'b1;
      end else begin
         pick1_s = 1'b0;
      end
   end
`endif

   assign req_any_s = REQ0 | REQ1;

   // Arbitration FSM with all outputs registered; reset has top priority.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 4'd0;
         owner_q     <= 1'b0;
         gnt0_q      <= 1'b0;
         gnt1_q      <= 1'b0;
         valid0_q    <= 1'b0;
         valid1_q    <= 1'b0;
         busy_q      <= 1'b0;
         result_q    <= 8'h00;
         add_data1_q <= 8'h00;
         add_data2_q <= 8'h00;
`ifdef ADD_ARB_ROUND_ROBIN_EN
         last_q      <= 1'b1;
`endif
      end else begin
         // Pulses default low; they are set for exactly one cycle below.
         gnt0_q   <= 1'b0;
         gnt1_q   <= 1'b0;
         valid0_q <= 1'b0;
         valid1_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (req_any_s) begin
                  owner_q     <= pick1_s;
                  gnt0_q      <= ~pick1_s;
                  gnt1_q      <= pick1_s;
                  add_data1_q <= pick1_s ? DATA1_1 : DATA1_0;
                  add_data2_q <= pick1_s ? DATA2_1 : DATA2_0;
                  cnt_q       <= CNT_LOAD;
                  state_q     <= ST_WAIT;
                  busy_q      <= 1'b1;
`ifdef ADD_ARB_ROUND_ROBIN_EN
                  last_q      <= pick1_s;
`endif
               end else begin
                  // Idle with no request: every output except RESULT is 0.
                  add_data1_q <= 8'h00;
                  add_data2_q <= 8'h00;
                  state_q     <= ST_IDLE;
                  busy_q      <= 1'b0;
               end
            end
            ST_WAIT: begin
               // Requests are ignored here; operands stay as granted.
               if (cnt_q != 4'd0) begin
                  cnt_q  <= cnt_q - 4'd1;
                  busy_q <= 1'b1;
               end else begin
                  result_q <= ADD_RESULT;
                  valid0_q <= ~owner_q;
                  valid1_q <= owner_q;
                  state_q  <= ST_IDLE;
                  busy_q   <= 1'b0;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign GNT0      = gnt0_q;
   assign GNT1      = gnt1_q;
   assign VALID0    = valid0_q;
   assign VALID1    = valid1_q;
   assign BUSY      = busy_q;
   assign RESULT    = result_q;
   assign ADD_DATA1 = add_data1_q;
   assign ADD_DATA2 = add_data2_q;

endmodule

// File: tb/tb_add_arbiter.sv
// -----------------------------------------------------------------------------
// tb_add_arbiter
//   Directed bench for add_arbiter. Two instances share the clock and reset:
//   dut_a with LAT=1 and dut_b with LAT=3. Each has an ideal combinational
//   adder on its ADD port (8-bit, carry discarded). Expected values are hand
//   computed. Outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_add_arbiter;

   logic CLK = 1'b0;
   logic RESET;

   logic       req0_a, req1_a, gnt0_a, gnt1_a, v0_a, v1_a, busy_a;
   logic [7:0] d10_a, d20_a, d11_a, d21_a, res_a, ad1_a, ad2_a, addres_a;
   logic       req0_b, req1_b, gnt0_b, gnt1_b, v0_b, v1_b, busy_b;
   logic [7:0] d10_b, d20_b, d11_b, d21_b, res_b, ad1_b, ad2_b, addres_b;

   int vectors     = 0;
   int miscompares = 0;
   logic exp1;

   always #5 CLK = ~CLK;

   assign addres_a = ad1_a + ad2_a;
   assign addres_b = ad1_b + ad2_b;

   add_arbiter #(.LAT(1)) dut_a (
      .CLK(CLK), .RESET(RESET),
      .REQ0(req0_a), .DATA1_0(d10_a), .DATA2_0(d20_a),
      .REQ1(req1_a), .DATA1_1(d11_a), .DATA2_1(d21_a),
      .GNT0(gnt0_a), .GNT1(gnt1_a), .VALID0(v0_a), .VALID1(v1_a),
      .RESULT(res_a), .ADD_DATA1(ad1_a), .ADD_DATA2(ad2_a),
      .ADD_RESULT(addres_a), .BUSY(busy_a)
   );

   add_arbiter #(.LAT(3)) dut_b (
      .CLK(CLK), .RESET(RESET),
      .REQ0(req0_b), .DATA1_0(d10_b), .DATA2_0(d20_b),
      .REQ1(req1_b), .DATA1_1(d11_b), .DATA2_1(d21_b),
      .GNT0(gnt0_b), .GNT1(gnt1_b), .VALID0(v0_b), .VALID1(v1_b),
      .RESULT(res_b), .ADD_DATA1(ad1_b), .ADD_DATA2(ad2_b),
      .ADD_RESULT(addres_b), .BUSY(busy_b)
   );

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Packs the pulse outputs of one DUT: {gnt0,gnt1,valid0,valid1,busy}.
   function automatic logic [7:0] flags(input logic g0, input logic g1,
                                        input logic v0, input logic v1,
                                        input logic b);
      return {3'b000, g0, g1, v0, v1, b};
   endfunction

   initial begin
      RESET = 1'b1;
      req0_a = 1'b0; req1_a = 1'b0; d10_a = 8'h00; d20_a = 8'h00; d11_a = 8'h00; d21_a = 8'h00;
      req0_b = 1'b0; req1_b = 1'b0; d10_b = 8'h00; d20_b = 8'h00; d11_b = 8'h00; d21_b = 8'h00;
      step();
      step();
      // Reset state
      chk("rst_flags_a", flags(gnt0_a, gnt1_a, v0_a, v1_a, busy_a), 8'h00);
      chk("rst_flags_b", flags(gnt0_b, gnt1_b, v0_b, v1_b, busy_b), 8'h00);
      chk("rst_result_a", res_a, 8'h00);
      chk("rst_ad1_b", ad1_b, 8'h00);
      RESET = 1'b0;
      step();
      chk("idle_flags_a", flags(gnt0_a, gnt1_a, v0_a, v1_a, busy_a), 8'h00);

      // Both requests held on dut_a for 4 operations (LAT=1, 2 cycles each)
      req0_a = 1'b1; d10_a = 8'h01; d20_a = 8'h02;
      req1_a = 1'b1; d11_a = 8'h10; d21_a = 8'h20;
      for (int k = 0; k < 4; k++) begin
`ifdef ADD_ARB_ROUND_ROBIN_EN
         exp1 = (k % 2 == 1);
`else
         exp1 = 1'b0;
`endif
         step();
         chk($sformatf("hold_gnt_%0d", k), flags(gnt0_a, gnt1_a, v0_a, v1_a, busy_a),
             flags(~exp1, exp1, 1'b0, 1'b0, 1'b1));
         step();
         chk($sformatf("hold_valid_%0d", k), flags(gnt0_a, gnt1_a, v0_a, v1_a, busy_a),
             flags(1'b0, 1'b0, ~exp1, exp1, 1'b0));
         chk($sformatf("hold_result_%0d", k), res_a, exp1 ? 8'h30 : 8'h03);
      end

      // LAT=1: REQ0 with 0x12 + 0x34
      req1_a = 1'b0;
      d10_a = 8'h12; d20_a = 8'h34;
      step();
      chk("l1_gnt", flags(gnt0_a, gnt1_a, v0_a, v1_a, busy_a), flags(1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
      chk("l1_ad1", ad1_a, 8'h12);
      chk("l1_ad2", ad2_a, 8'h34);
      req0_a = 1'b0; d10_a = 8'hAA; d20_a = 8'hBB;
      step();
      chk("l1_valid", flags(gnt0_a, gnt1_a, v0_a, v1_a, busy_a), flags(1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
      chk("l1_result", res_a, 8'h46);
      step();
      chk("l1_after", flags(gnt0_a, gnt1_a, v0_a, v1_a, busy_a), 8'h00);
      chk("l1_hold_result", res_a, 8'h46);
      chk("l1_idle_ad1", ad1_a, 8'h00);

      // LAT=3: REQ1 with 0xFF + 0x01, carry discarded
      req1_b = 1'b1; d11_b = 8'hFF; d21_b = 8'h01; d10_b = 8'h77; d20_b = 8'h66;
      step();
      chk("l3_gnt", flags(gnt0_b, gnt1_b, v0_b, v1_b, busy_b), flags(1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
      chk("l3_ad1", ad1_b, 8'hFF);
      req1_b = 1'b0; d11_b = 8'h55; d21_b = 8'h44;
      step();
      chk("l3_w1", flags(gnt0_b, gnt1_b, v0_b, v1_b, busy_b), flags(1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
      chk("l3_w1_ad1", ad1_b, 8'hFF);
      chk("l3_w1_ad2", ad2_b, 8'h01);
      step();
      chk("l3_w2", flags(gnt0_b, gnt1_b, v0_b, v1_b, busy_b), flags(1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
      chk("l3_w2_ad2", ad2_b, 8'h01);
      step();
      chk("l3_valid", flags(gnt0_b, gnt1_b, v0_b, v1_b, busy_b), flags(1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
      chk("l3_result", res_b, 8'h00);
      step();
      chk("l3_after", flags(gnt0_b, gnt1_b, v0_b, v1_b, busy_b), 8'h00);

      // Operands change and REQ1 rises during WAIT
      req0_b = 1'b1; d10_b = 8'h10; d20_b = 8'h20;
      step();
      chk("ow_gnt0", flags(gnt0_b, gnt1_b, v0_b, v1_b, busy_b), flags(1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
      req0_b = 1'b0; d10_b = 8'h99; d20_b = 8'h88;
      req1_b = 1'b1; d11_b = 8'h03; d21_b = 8'h04;
      step();
      chk("ow_w1", flags(gnt0_b, gnt1_b, v0_b, v1_b, busy_b), flags(1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
      step();
      chk("ow_w2", flags(gnt0_b, gnt1_b, v0_b, v1_b, busy_b), flags(1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
      step();
      chk("ow_valid0", flags(gnt0_b, gnt1_b, v0_b, v1_b, busy_b), flags(1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
      chk("ow_result", res_b, 8'h30);
      step();
      chk("ow_gnt1", flags(gnt0_b, gnt1_b, v0_b, v1_b, busy_b), flags(1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
      chk("ow_gnt1_ad1", ad1_b, 8'h03);
      req1_b = 1'b0;
      step();
      step();
      step();
      chk("ow_valid1", flags(gnt0_b, gnt1_b, v0_b, v1_b, busy_b), flags(1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
      chk("ow_result1", res_b, 8'h07);

      // RESET in the second WAIT cycle (LAT=3)
      req0_b = 1'b1; d10_b = 8'h21; d20_b = 8'h02;
      step();
      chk("rw_gnt0", flags(gnt0_b, gnt1_b, v0_b, v1_b, busy_b), flags(1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
      req0_b = 1'b0;
      step();
      RESET = 1'b1;
      req0_b = 1'b1; req1_b = 1'b1; d11_b = 8'h0A; d21_b = 8'h0B;
      step();
      chk("rw_rst_flags", flags(gnt0_b, gnt1_b, v0_b, v1_b, busy_b), 8'h00);
      chk("rw_rst_result", res_b, 8'h00);
      chk("rw_rst_ad1", ad1_b, 8'h00);
      chk("rw_rst_ad2", ad2_b, 8'h00);
      RESET = 1'b0;
      step();
      chk("rw_regrant0", flags(gnt0_b, gnt1_b, v0_b, v1_b, busy_b), flags(1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
      chk("rw_regrant_ad1", ad1_b, 8'h21);
      req0_b = 1'b0; req1_b = 1'b0;
      step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
